// File: rtl/data_mem_resp_if.sv
// LSU data port bundle: req/gnt handshake plus the fixed-latency response channel.
// Signal names are seen from the memory side, so the slave modport matches them.
interface data_mem_resp_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                 data_req_i;
  logic [AddrWidth-1:0] data_addr_i;
  logic                 data_we_i;
  logic [3:0]           data_be_i;
  logic [DataWidth-1:0] data_wdata_i;
  logic                 data_gnt_o;
  logic                 data_rvalid_o;
  logic                 data_err_o;
  logic [DataWidth-1:0] data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
  );
endinterface

// File: rtl/data_mem_resp.sv
// Byte-enabled word memory behind the LSU data port: optional grant stall,
// fixed-latency non-stalling response pipeline, range-checked addressing.
module data_mem_resp #(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          Depth       = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          GntStall    = 0,
  parameter int unsigned          RespLatency = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_resp_if.slave  data_if
);
  localparam int unsigned Lanes = DataWidth / 8;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = (GntStall > 0) ? $clog2(GntStall + 1) : 1;
  localparam logic [AddrWidth:0] SpanBytes = (AddrWidth+1)'(Depth) << 2;

  if (RespLatency < 1 || Depth < 1) begin : g_bad_params
    $error("data_mem_resp: RespLatency and Depth must both be at least 1");
  end

  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic [DataWidth-1:0] rdata;
  } resp_t;

  logic [DataWidth-1:0] mem [Depth];
  logic [CntW-1:0]      wait_q, wait_d;
  resp_t                pipe_q [RespLatency];
  resp_t                resp_d;

  logic                 gnt, in_range;
  logic [AddrWidth-1:0] off;
  logic [IdxW-1:0]      idx;
  logic                 unused_addr;

  assign off         = data_if.data_addr_i - BaseAddr;
  assign in_range    = (data_if.data_addr_i >= BaseAddr) && ({1'b0, off} < SpanBytes);
  assign idx         = off[IdxW+1:2];
  assign unused_addr = ^{off[1:0], off[AddrWidth-1:IdxW+2]};

  assign gnt                = data_if.data_req_i && (wait_q == CntW'(GntStall));
  assign data_if.data_gnt_o = gnt;

  // Counter only ever reaches GntStall, where gnt fires and it clears.
  always_comb begin
    wait_d = wait_q;
    if (!data_if.data_req_i || gnt) wait_d = '0;
    else                            wait_d = wait_q + 1'b1;
  end

  always_comb begin
    resp_d       = '0;
    resp_d.vld   = gnt;
    resp_d.err   = gnt && !in_range;
    if (gnt && in_range && !data_if.data_we_i) resp_d.rdata = mem[idx];
  end

  // Array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (gnt && in_range && data_if.data_we_i) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (data_if.data_be_i[i]) mem[idx][8*i +: 8] <= data_if.data_wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      for (int unsigned k = 0; k < RespLatency; k++) pipe_q[k] <= '0;
    end else begin
      wait_q    <= wait_d;
      pipe_q[0] <= resp_d;
      for (int unsigned k = 1; k < RespLatency; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign data_if.data_rvalid_o = pipe_q[RespLatency-1].vld;
  assign data_if.data_err_o    = pipe_q[RespLatency-1].err;
  assign data_if.data_rdata_o  = pipe_q[RespLatency-1].rdata;
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench: three responder configurations (stall/latency 0/1, 3/4, 0/3)
// sharing address/data stimulus, each with its own request line.
module tb_data_mem_resp;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       req;
  logic             we;
  logic [31:0]      addr, wdata;
  logic [3:0]       be;
  logic [2:0]       gnt, rv, er;
  logic [2:0][31:0] rd;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned GS = (g == 1) ? 3 : 0;
    localparam int unsigned RL = (g == 0) ? 1 : (g == 1) ? 4 : 3;
    data_mem_resp_if #(.AddrWidth(32), .DataWidth(32)) u_if ();
    assign u_if.data_req_i   = req[g];
    assign u_if.data_addr_i  = addr;
    assign u_if.data_we_i    = we;
    assign u_if.data_be_i    = be;
    assign u_if.data_wdata_i = wdata;
    assign gnt[g] = u_if.data_gnt_o;
    assign rv[g]  = u_if.data_rvalid_o;
    assign er[g]  = u_if.data_err_o;
    assign rd[g]  = u_if.data_rdata_o;
    data_mem_resp #(.GntStall(GS), .RespLatency(RL)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_if(u_if.slave)
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Full stalled transaction on the GntStall=3 / RespLatency=4 instance.
  task automatic d1_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    req[1] = 1'b1; we = w; addr = a; be = 4'hF; wdata = wd;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("d1 gnt c%0d", c), gnt[1], c == 3);
      if (c < 3) @(negedge clk);
    end
    @(negedge clk);
    req[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1 chk($sformatf("d1 rvalid k%0d", k), rv[1], k == 4);
      if (k == 4) begin
        chk("d1 rdata", rd[1], exp_rd);
        chk("d1 err", er[1], 1'b0);
      end
      if (k < 5) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[3]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD};
    vt[6]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD};
    vt[8]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[10] = '{1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
    vt[11] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'hCAFE_F00D};
    vt[12] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0};
    vt[13] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         1'b0, 32'h0BAD_F00D};

    req = '0; we = 1'b0; addr = '0; wdata = '0; be = '0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst gnt", gnt, 3'b000);
    chk("rst rvalid", rv, 3'b000);
    chk("rst err", er, 3'b000);
    for (int g = 0; g < 3; g++) chk($sformatf("rst rdata%0d", g), rd[g], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle grant, one-cycle response latency.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req[0] = 1'b1; we = vt[i].we; addr = vt[i].addr; be = vt[i].be; wdata = vt[i].wdata;
      #1;
      chk($sformatf("v%0d gnt", i), gnt[0], 1'b1);
      chk($sformatf("v%0d idle", i), rv[0], 1'b0);
      @(negedge clk);
      req[0] = 1'b0;
      #1;
      chk($sformatf("v%0d rvalid", i), rv[0], 1'b1);
      chk($sformatf("v%0d err", i), er[0], vt[i].err);
      chk($sformatf("v%0d rdata", i), rd[0], vt[i].rdata);
    end

    // Stalled grant, then request dropped mid-stall and reasserted.
    @(negedge clk);
    d1_txn(1'b1, 32'h40, 32'h5A5A_1234, 32'h0);
    @(negedge clk);
    req[1] = 1'b1; we = 1'b0; addr = 32'h40;
    #1 chk("d1 drop c0", gnt[1], 1'b0);
    @(negedge clk);
    #1 chk("d1 drop c1", gnt[1], 1'b0);
    @(negedge clk);
    req[1] = 1'b0;
    #1 chk("d1 drop low", gnt[1], 1'b0);
    @(negedge clk);
    d1_txn(1'b0, 32'h40, 32'h0, 32'h5A5A_1234);

    // Back-to-back on the 3-cycle latency instance.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req[2] = 1'b1; we = 1'b1; addr = 32'(4 * i); be = 4'hF; wdata = pat(i);
    end
    @(negedge clk);
    req[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk($sformatf("b2b rvalid t%0d", t), rv[2], (t >= 3 && t < 11));
      chk($sformatf("b2b rdata t%0d", t), rd[2], (t >= 3 && t < 11) ? pat(t - 3) : 32'h0);
      if (t < 8) begin
        req[2] = 1'b1; we = 1'b0; addr = 32'(4 * t);
        #1 chk($sformatf("b2b gnt t%0d", t), gnt[2], 1'b1);
      end else begin
        req[2] = 1'b0;
      end
    end

    // Reset with three responses in flight and a partial stall on the other instance.
    @(negedge clk);
    req[2] = 1'b1; we = 1'b0; addr = 32'h0;
    @(negedge clk);
    addr = 32'h4; req[1] = 1'b1;
    @(negedge clk);
    we = 1'b1; addr = 32'h80; wdata = 32'hFEED_FACE; be = 4'hF;
    @(negedge clk);
    req[2] = 1'b0;
    #1;
    chk("pre-rst rvalid", rv[2], 1'b1);
    chk("pre-rst rdata", rd[2], pat(0));
    chk("pre-rst d1 gnt", gnt[1], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst async rvalid", rv[2], 1'b0);
    chk("rst async rdata", rd[2], 32'h0);
    chk("rst async err", er[2], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      chk($sformatf("post-rst rvalid t%0d", t), rv[2], 1'b0);
      chk($sformatf("post-rst d1 gnt t%0d", t), gnt[1], t == 3);
      if (t == 3) req[1] = 1'b0;
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk($sformatf("retained rvalid t%0d", t), rv[2], t == 3);
      chk($sformatf("retained rdata t%0d", t), rd[2], (t == 3) ? 32'hFEED_FACE : 32'h0);
      if (t == 0) begin
        req[2] = 1'b1; we = 1'b0; addr = 32'h80;
      end else begin
        req[2] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
